decode_ctrl: RTL and testbench
==============================

Name: decode_ctrl

Overview:
- IF/ID decode-stage controller for the RV32I pipeline.
- Holds one fetched instruction in a single-entry decode register with valid/ready handshakes on both sides.
- Generates the 3-bit immediate-select code for the immediate generator, extracts register fields, and detects illegal opcodes.
- Inserts load-use bubbles and discards wrong-path instructions on branch/jump flush.

Parameters:
- DATA_WIDTH, 32, width of instruction and PC.
- CNT_WIDTH, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- instr_i  in  DATA_WIDTH  fetched instruction.
- pc_i  in  DATA_WIDTH  PC of instr_i.
- instr_valid_i  in  1  fetch beat valid.
- instr_ready_o  out  1  decode can accept a beat.
- id_valid_o  out  1  decoded instruction valid to EX.
- id_ready_i  in  1  EX accepts the instruction.
- flush_i  in  1  branch/jump redirect; kill the held and incoming instruction.
- ex_mem_read_i  in  1  instruction currently in EX is a load.
- ex_rd_i  in  5  destination register of the EX instruction.
- imm_o  out  25  held instruction bits [31:7], raw field for the immediate generator.
- imm_src_o  out  3  immediate select: 000 none/R, 001 I, 010 S, 011 B, 100 U, 101 J.
- rs1_o, rs2_o, rd_o  out  5 each  register fields [19:15], [24:20], [11:7].
- pc_o  out  DATA_WIDTH  held PC.
- illegal_o  out  1  held instruction has an unsupported opcode; qualified by the held state.
- stall_o  out  1  load-use bubble this cycle.
- stall_cnt_o  out  CNT_WIDTH  saturating count of bubble cycles.

Behaviour:
- States: EMPTY, HOLD. The decode register (instr, pc) is loaded on every accepted beat.
- Reset (rst_n=0 at edge): state EMPTY; decode register 0; stall_cnt_o 0. All outputs then read 0, except instr_ready_o, which reads 1.
- Opcode decode (from instr[6:0]):
  - 0010011, 0000011, 1100111, 1110011 -> 001 (I).
  - 0100011 -> 010 (S).
  - 1100011 -> 011 (B).
  - 0110111, 0010111 -> 100 (U).
  - 1101111 -> 101 (J).
  - 0110011 -> 000 (R).
  - Any other opcode -> 000 with illegal_o=1.
- Register use:
  - rs1 is used by every type except U and J.
  - rs2 is used by R, S and B only.
- Hazard (combinational): state==HOLD && ex_mem_read_i && ex_rd_i!=0 && ((rs1 used && rs1==ex_rd_i) || (rs2 used && rs2==ex_rd_i)).
- Handshake outputs:
  - id_valid_o = HOLD && !hazard && !flush_i.
  - stall_o = hazard && !flush_i.
  - instr_ready_o = EMPTY || (id_valid_o && id_ready_i) || flush_i.
  - A beat is accepted when instr_valid_i && instr_ready_o && !flush_i.
- Transitions (priority order):
  - flush_i=1: -> EMPTY. The held instruction and any same-cycle incoming beat are discarded. Flush overrides hazard and handshake.
  - EMPTY: beat accepted -> HOLD; else stay EMPTY.
  - HOLD, id_valid_o && id_ready_i: beat accepted -> HOLD with new contents (back-to-back, zero-bubble throughput); no beat -> EMPTY.
  - HOLD, otherwise (hazard or EX backpressure): stay HOLD; register and outputs unchanged.
- Latency: a beat accepted at edge N is presented with id_valid_o=1 after edge N (one cycle), absent hazard or flush.
- stall_cnt_o increments by 1 at each edge where stall_o=1, saturates at all-ones, and does not wrap. Only reset clears it; flush does not.
- Reset asserted mid-operation: the held instruction is lost and the block returns to the reset values above.
- Outputs in EMPTY: imm_src_o, fields, pc_o and illegal_o are driven from the decode register but are don't-care. The bench checks them only when id_valid_o=1; illegal_o is checked only in HOLD.

Test Plan:
- Basic flow: reset, then push instr 0x00500093 (addi x1,x0,5) at pc 0x100 with id_ready_i=1 -> one cycle later id_valid_o=1, imm_src_o=001, rd_o=1, rs1_o=0, pc_o=0x100; instr_ready_o stays 1.
- Back-to-back stream: push sw 0x0020A223 then beq 0x00208463 -> consecutive cycles show imm_src_o 010 then 011 with no bubble; an unsupported opcode 0x0000007F -> illegal_o=1.
- Load-use bubble: hold add x3,x1,x2 (0x002081B3) with ex_mem_read_i=1, ex_rd_i=2 -> stall_o=1, id_valid_o=0, instr_ready_o=0, stall_cnt_o 0->1. Drop ex_mem_read_i next cycle -> id_valid_o=1.
- False-hazard masking: hold lui x5 (0x123452B7) with ex_mem_read_i=1, ex_rd_i=0x05 (rs1/rs2 fields unused) -> no stall. ex_rd_i=0 with a matching field -> no stall.
- Backpressure and flush: id_ready_i=0 for 3 cycles -> outputs stable, instr_ready_o=0. Then flush_i=1 with instr_valid_i=1 -> next cycle EMPTY, id_valid_o=0, incoming beat not presented.
- Counter saturation and reset: with CNT_WIDTH=4, hold a hazard for 20 cycles -> stall_cnt_o=0xF. Assert rst_n=0 while in HOLD -> next edge id_valid_o=0, stall_cnt_o=0, instr_ready_o=1.

Source files
------------

// File: rtl/decode_ctrl.sv
// RV32I decode-stage controller: single-entry IF/ID register, immediate-select
// decode, register-field extraction, load-use bubbles and flush handling.
module decode_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    output logic                  id_valid_o,
    input  logic                  id_ready_i,
    input  logic                  flush_i,
    input  logic                  ex_mem_read_i,
    input  logic [4:0]            ex_rd_i,
    output logic [24:0]           imm_o,
    output logic [2:0]            imm_src_o,
    output logic [4:0]            rs1_o,
    output logic [4:0]            rs2_o,
    output logic [4:0]            rd_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  illegal_o,
    output logic                  stall_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

    typedef enum logic {
        EMPTY,
        HOLD
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic [2:0] imm_src;
    logic       bad_op;
    logic       use_rs1;
    logic       use_rs2;
    logic       hazard;
    logic       handshake;
    logic       accept;

    always_comb begin
        imm_src = 3'b000;
        bad_op  = 1'b0;
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        case (instr_q[6:0])
            7'b0010011, 7'b0000011,
            7'b1100111, 7'b1110011: imm_src = 3'b001;
            7'b0100011: begin
                imm_src = 3'b010;
                use_rs2 = 1'b1;
            end
            7'b1100011: begin
                imm_src = 3'b011;
                use_rs2 = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                imm_src = 3'b100;
                use_rs1 = 1'b0;
            end
            7'b1101111: begin
                imm_src = 3'b101;
                use_rs1 = 1'b0;
            end
            7'b0110011: use_rs2 = 1'b1;
            default: begin
                // no real operands, so never stall on garbage fields
                bad_op  = 1'b1;
                use_rs1 = 1'b0;
            end
        endcase
    end

    assign rs1_o = instr_q[19:15];
    assign rs2_o = instr_q[24:20];
    assign rd_o  = instr_q[11:7];

    assign hazard = (state_q == HOLD) && ex_mem_read_i && (ex_rd_i != 5'd0)
                 && ((use_rs1 && (rs1_o == ex_rd_i))
                  || (use_rs2 && (rs2_o == ex_rd_i)));

    assign id_valid_o    = (state_q == HOLD) && !hazard && !flush_i;
    assign stall_o       = hazard && !flush_i;
    assign handshake     = id_valid_o && id_ready_i;
    assign instr_ready_o = (state_q == EMPTY) || handshake || flush_i;
    assign accept        = instr_valid_i && instr_ready_o && !flush_i;

    assign imm_o       = instr_q[31:7];
    assign imm_src_o   = imm_src;
    assign pc_o        = pc_q;
    assign illegal_o   = (state_q == HOLD) && bad_op;
    assign stall_cnt_o = cnt_q;

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) state_d = HOLD;
                HOLD: begin
                    if (handshake) state_d = accept ? HOLD : EMPTY;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            instr_q <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                instr_q <= instr_i;
                pc_q    <= pc_i;
            end
            if (stall_o && (cnt_q != '1)) cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_decode_ctrl.sv
// Scoreboard bench for decode_ctrl: directed beats push expectations,
// a negedge monitor pops and compares on every EX handshake.
module tb_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic        id_valid_o;
    logic        id_ready_i;
    logic        flush_i;
    logic        ex_mem_read_i;
    logic [4:0]  ex_rd_i;
    logic [24:0] imm_o;
    logic [2:0]  imm_src_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [4:0]  rd_o;
    logic [31:0] pc_o;
    logic        illegal_o;
    logic        stall_o;
    logic [3:0]  stall_cnt_o;

    decode_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .instr_i(instr_i),
        .pc_i(pc_i),
        .instr_valid_i(instr_valid_i),
        .instr_ready_o(instr_ready_o),
        .id_valid_o(id_valid_o),
        .id_ready_i(id_ready_i),
        .flush_i(flush_i),
        .ex_mem_read_i(ex_mem_read_i),
        .ex_rd_i(ex_rd_i),
        .imm_o(imm_o),
        .imm_src_o(imm_src_o),
        .rs1_o(rs1_o),
        .rs2_o(rs2_o),
        .rd_o(rd_o),
        .pc_o(pc_o),
        .illegal_o(illegal_o),
        .stall_o(stall_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  src;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] ins, input logic [31:0] pc,
                        input logic [2:0] src, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic ill);
        exp_t e;
        instr_i       = ins;
        pc_i          = pc;
        instr_valid_i = 1'b1;
        e.instr = ins;
        e.pc    = pc;
        e.src   = src;
        e.rd    = rd;
        e.rs1   = rs1;
        e.rs2   = rs2;
        e.ill   = ill;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && id_valid_o === 1'b1 && id_ready_i === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_out", pc_o, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                logic [31:0] w;
                e = sb.pop_front();
                w = e.instr;
                chk("sb_imm_src", {29'd0, imm_src_o}, {29'd0, e.src});
                chk("sb_rd", {27'd0, rd_o}, {27'd0, e.rd});
                chk("sb_rs1", {27'd0, rs1_o}, {27'd0, e.rs1});
                chk("sb_rs2", {27'd0, rs2_o}, {27'd0, e.rs2});
                chk("sb_pc", pc_o, e.pc);
                chk("sb_imm", {7'd0, imm_o}, {7'd0, w[31:7]});
                chk("sb_illegal", {31'd0, illegal_o}, {31'd0, e.ill});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        instr_i       = '0;
        pc_i          = '0;
        instr_valid_i = 1'b0;
        id_ready_i    = 1'b1;
        flush_i       = 1'b0;
        ex_mem_read_i = 1'b0;
        ex_rd_i       = '0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_ready", {31'd0, instr_ready_o}, 32'd1);
        chk("rst_valid", {31'd0, id_valid_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_cnt", {28'd0, stall_cnt_o}, 32'd0);
        chk("rst_illegal", {31'd0, illegal_o}, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_src", {29'd0, imm_src_o}, 32'd0);

        // basic flow: addi x1,x0,5
        tick();
        rst_n = 1'b1;
        beat(32'h0050_0093, 32'h100, 3'b001, 5'd1, 5'd0, 5'd5, 1'b0);
        @(negedge clk);
        chk("basic_ready_empty", {31'd0, instr_ready_o}, 32'd1);
        tick();
        instr_valid_i = 1'b0;
        @(negedge clk);
        chk("basic_valid", {31'd0, id_valid_o}, 32'd1);
        chk("basic_ready_hold", {31'd0, instr_ready_o}, 32'd1);

        // back-to-back: sw, beq, illegal
        tick();
        beat(32'h0020_A223, 32'h104, 3'b010, 5'd4, 5'd1, 5'd2, 1'b0);
        tick();
        beat(32'h0020_8463, 32'h108, 3'b011, 5'd8, 5'd1, 5'd2, 1'b0);
        @(negedge clk);
        chk("b2b_valid_sw", {31'd0, id_valid_o}, 32'd1);
        tick();
        beat(32'h0000_007F, 32'h10C, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1);
        @(negedge clk);
        chk("b2b_valid_beq", {31'd0, id_valid_o}, 32'd1);
        tick();
        instr_valid_i = 1'b0;
        @(negedge clk);
        chk("b2b_valid_ill", {31'd0, id_valid_o}, 32'd1);
        chk("b2b_illegal", {31'd0, illegal_o}, 32'd1);

        // load-use: add x3,x1,x2 with load to x2 in EX
        tick();
        beat(32'h0020_81B3, 32'h110, 3'b000, 5'd3, 5'd1, 5'd2, 1'b0);
        tick();
        instr_valid_i = 1'b0;
        ex_mem_read_i = 1'b1;
        ex_rd_i       = 5'd2;
        @(negedge clk);
        chk("lu_stall", {31'd0, stall_o}, 32'd1);
        chk("lu_valid", {31'd0, id_valid_o}, 32'd0);
        chk("lu_ready", {31'd0, instr_ready_o}, 32'd0);
        chk("lu_cnt0", {28'd0, stall_cnt_o}, 32'd0);
        tick();
        ex_mem_read_i = 1'b0;
        @(negedge clk);
        chk("lu_cnt1", {28'd0, stall_cnt_o}, 32'd1);
        chk("lu_release", {31'd0, id_valid_o}, 32'd1);

        // false hazard: lui x5 (fields rs1=8, rs2=3 unused)
        tick();
        beat(32'h1234_52B7, 32'h114, 3'b100, 5'd5, 5'd8, 5'd3, 1'b0);
        tick();
        instr_valid_i = 1'b0;
        ex_mem_read_i = 1'b1;
        ex_rd_i       = 5'd8;
        id_ready_i    = 1'b0;
        @(negedge clk);
        chk("fh_lui_rs1_stall", {31'd0, stall_o}, 32'd0);
        chk("fh_lui_rs1_valid", {31'd0, id_valid_o}, 32'd1);
        tick();
        ex_rd_i    = 5'd5;
        id_ready_i = 1'b1;
        @(negedge clk);
        chk("fh_lui_rd_stall", {31'd0, stall_o}, 32'd0);

        // ex_rd=0 against addi with rs1=x0
        tick();
        ex_mem_read_i = 1'b0;
        beat(32'h0050_0093, 32'h118, 3'b001, 5'd1, 5'd0, 5'd5, 1'b0);
        tick();
        instr_valid_i = 1'b0;
        ex_mem_read_i = 1'b1;
        ex_rd_i       = 5'd0;
        @(negedge clk);
        chk("fh_x0_stall", {31'd0, stall_o}, 32'd0);
        chk("fh_x0_valid", {31'd0, id_valid_o}, 32'd1);

        // backpressure then flush
        tick();
        ex_mem_read_i = 1'b0;
        beat(32'h0020_8463, 32'h11C, 3'b011, 5'd8, 5'd1, 5'd2, 1'b0);
        tick();
        id_ready_i    = 1'b0;
        instr_i       = 32'h0020_A223;
        pc_i          = 32'h200;
        instr_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, id_valid_o}, 32'd1);
            chk("bp_ready", {31'd0, instr_ready_o}, 32'd0);
            chk("bp_src", {29'd0, imm_src_o}, 32'd3);
            chk("bp_pc", pc_o, 32'h11C);
            tick();
        end
        flush_i = 1'b1;
        void'(sb.pop_front());
        @(negedge clk);
        chk("fl_valid", {31'd0, id_valid_o}, 32'd0);
        chk("fl_ready", {31'd0, instr_ready_o}, 32'd1);
        tick();
        flush_i       = 1'b0;
        instr_valid_i = 1'b0;
        id_ready_i    = 1'b1;
        @(negedge clk);
        chk("fl_empty_valid", {31'd0, id_valid_o}, 32'd0);
        chk("fl_empty_ready", {31'd0, instr_ready_o}, 32'd1);
        chk("fl_cnt_kept", {28'd0, stall_cnt_o}, 32'd1);

        // saturation: add x3,x1,x2 stalled on x1 for 20 cycles
        tick();
        beat(32'h0020_81B3, 32'h120, 3'b000, 5'd3, 5'd1, 5'd2, 1'b0);
        tick();
        instr_valid_i = 1'b0;
        ex_mem_read_i = 1'b1;
        ex_rd_i       = 5'd1;
        repeat (20) tick();
        @(negedge clk);
        chk("sat_cnt", {28'd0, stall_cnt_o}, 32'hF);
        chk("sat_stall", {31'd0, stall_o}, 32'd1);

        // reset while holding
        tick();
        rst_n = 1'b0;
        void'(sb.pop_front());
        tick();
        rst_n         = 1'b1;
        ex_mem_read_i = 1'b0;
        @(negedge clk);
        chk("mrst_valid", {31'd0, id_valid_o}, 32'd0);
        chk("mrst_cnt", {28'd0, stall_cnt_o}, 32'd0);
        chk("mrst_ready", {31'd0, instr_ready_o}, 32'd1);

        tick();
        tick();
        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
